// File: rtl/acc_regfile.sv
// acc_regfile: accumulator/activation register file for the NN accelerator datapath.
// Multi-lane overwrite/accumulate writes with wrap-around, a small activation bank,
// and a handshaked drain engine that streams every accumulator to the next stage.
// Build option: define ACC_SAT_EN to make accumulate a signed saturating add;
// by default accumulate wraps modulo 2^DATA_W.
module acc_regfile #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned LANES     = 4,
    parameter int unsigned DEPTH     = 32,
    parameter int unsigned ACT_DEPTH = 4
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         clr,
    input  logic [LANES*DATA_W-1:0]      wdata,
    input  logic [LANES-1:0]             word_en,
    input  logic                         acc_wen,
    input  logic                         acc_mode,
    input  logic [$clog2(DEPTH)-1:0]     acc_sel_w,
    input  logic [$clog2(DEPTH)-1:0]     acc_sel_r,
    output logic [LANES*DATA_W-1:0]      rdata_acc,
    input  logic                         act_wen,
    input  logic [$clog2(ACT_DEPTH)-1:0] act_sel_w,
    input  logic [$clog2(ACT_DEPTH)-1:0] act_sel_r,
    output logic [DATA_W-1:0]            rdata_act,
    input  logic                         drain_start,
    output logic                         drain_busy,
    output logic                         drain_valid,
    input  logic                         drain_ready,
    output logic [DATA_W-1:0]            drain_data,
    output logic [$clog2(DEPTH)-1:0]     drain_idx,
    output logic                         drain_last,
    output logic                         drain_done
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StRun, StDone} drain_state_e;

    logic [DATA_W-1:0] acc_q [DEPTH];
    logic [DATA_W-1:0] acc_d [DEPTH];
    logic [DATA_W-1:0] act_q [ACT_DEPTH];

    logic [DATA_W-1:0] lane_wdata [LANES];
    logic [AW-1:0]     lane_widx  [LANES];

    drain_state_e  state_q;
    logic [AW-1:0] drain_idx_q;
    logic          drain_busy_q;
    logic          drain_valid_q;
    logic          drain_done_q;

    // Accumulate add: wrapping by default, signed saturating when ACC_SAT_EN is defined.
    function automatic logic [DATA_W-1:0] acc_add(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] sum;
        sum = a + b;
`ifdef ACC_SAT_EN
        // Overflow only when both operands share a sign that the sum does not.
        if ((a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1])) begin
            sum = a[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end
`endif
        return sum;
    endfunction

    // Per-lane data slice, wrapped write index and wrapped read port.
    for (genvar i = 0; i < int'(LANES); i++) begin : g_lane
        assign lane_wdata[i] = wdata[i*DATA_W +: DATA_W];
        assign lane_widx[i]  = acc_sel_w + AW'(i);
        assign rdata_acc[i*DATA_W +: DATA_W] = acc_q[acc_sel_r + AW'(i)];
    end

    // Next accumulator state; writes are frozen while a drain is in flight.
    always_comb begin
        acc_d = acc_q;
        if (acc_wen && !drain_busy_q) begin
            for (int i = 0; i < int'(LANES); i++) begin
                if (word_en[i]) begin
                    acc_d[lane_widx[i]] = acc_mode ? acc_add(acc_q[lane_widx[i]], lane_wdata[i])
                                                   : lane_wdata[i];
                end
            end
        end
    end

    // Accumulator storage; reset and clear both zero every entry.
    always_ff @(posedge CLK) begin
        if (RST || clr) begin
            for (int e = 0; e < int'(DEPTH); e++) begin
                acc_q[e] <= '0;
            end
        end else begin
            acc_q <= acc_d;
        end
    end

    // Activation bank, written from lane 0; independent of the drain engine.
    always_ff @(posedge CLK) begin
        if (RST || clr) begin
            for (int e = 0; e < int'(ACT_DEPTH); e++) begin
                act_q[e] <= '0;
            end
        end else if (act_wen) begin
            act_q[act_sel_w] <= lane_wdata[0];
        end
    end

    // Drain engine: streams acc[0..DEPTH-1] on valid/ready, then pulses done for one cycle.
    always_ff @(posedge CLK) begin
        if (RST || clr) begin
            state_q       <= StIdle;
            drain_idx_q   <= '0;
            drain_busy_q  <= 1'b0;
            drain_valid_q <= 1'b0;
            drain_done_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (drain_start) begin
                        state_q       <= StRun;
                        drain_idx_q   <= '0;
                        drain_busy_q  <= 1'b1;
                        drain_valid_q <= 1'b1;
                    end
                end
                StRun: begin
                    if (drain_ready) begin
                        if (drain_idx_q == AW'(DEPTH - 1)) begin
                            state_q       <= StDone;
                            drain_valid_q <= 1'b0;
                            drain_done_q  <= 1'b1;
                        end else begin
                            drain_idx_q <= drain_idx_q + 1'b1;
                        end
                    end
                end
                StDone: begin
                    state_q      <= StIdle;
                    drain_idx_q  <= '0;
                    drain_busy_q <= 1'b0;
                    drain_done_q <= 1'b0;
                end
                default: begin
                    state_q       <= StIdle;
                    drain_idx_q   <= '0;
                    drain_busy_q  <= 1'b0;
                    drain_valid_q <= 1'b0;
                    drain_done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rdata_act   = act_q[act_sel_r];
    assign drain_busy  = drain_busy_q;
    assign drain_valid = drain_valid_q;
    assign drain_idx   = drain_idx_q;
    assign drain_data  = acc_q[drain_idx_q];
    assign drain_last  = drain_valid_q && (drain_idx_q == AW'(DEPTH - 1));
    assign drain_done  = drain_done_q;

endmodule

// File: tb/tb_acc_regfile.sv
// tb_acc_regfile: randomized bench for acc_regfile with an array-based reference model and a
// drain scoreboard. Define ACC_SAT_EN here as for the RTL to model saturating accumulate.
module tb_acc_regfile;

    localparam int DW = 32;
    localparam int L  = 4;
    localparam int D  = 32;
    localparam int AD = 4;
    localparam longint SMAX = 2147483647;
    localparam longint SMIN = -SMAX - 1;

    logic          CLK = 1'b0;
    logic          RST;
    logic          clr;
    logic [L*DW-1:0] wdata;
    logic [L-1:0]  word_en;
    logic          acc_wen;
    logic          acc_mode;
    logic [4:0]    acc_sel_w;
    logic [4:0]    acc_sel_r;
    logic [L*DW-1:0] rdata_acc;
    logic          act_wen;
    logic [1:0]    act_sel_w;
    logic [1:0]    act_sel_r;
    logic [DW-1:0] rdata_act;
    logic          drain_start;
    logic          drain_busy;
    logic          drain_valid;
    logic          drain_ready;
    logic [DW-1:0] drain_data;
    logic [4:0]    drain_idx;
    logic          drain_last;
    logic          drain_done;

    acc_regfile #(.DATA_W(DW), .LANES(L), .DEPTH(D), .ACT_DEPTH(AD)) dut (
        .CLK(CLK), .RST(RST), .clr(clr), .wdata(wdata), .word_en(word_en),
        .acc_wen(acc_wen), .acc_mode(acc_mode), .acc_sel_w(acc_sel_w),
        .acc_sel_r(acc_sel_r), .rdata_acc(rdata_acc), .act_wen(act_wen),
        .act_sel_w(act_sel_w), .act_sel_r(act_sel_r), .rdata_act(rdata_act),
        .drain_start(drain_start), .drain_busy(drain_busy), .drain_valid(drain_valid),
        .drain_ready(drain_ready), .drain_data(drain_data), .drain_idx(drain_idx),
        .drain_last(drain_last), .drain_done(drain_done)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;

    logic [DW-1:0] model_acc [D];
    logic [DW-1:0] model_act [AD];

    typedef struct packed {
        logic [DW-1:0] data;
        logic [4:0]    idx;
        logic          last;
    } drain_exp_t;
    drain_exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end
    endtask

    // Reference accumulate: plain integer arithmetic, clamped when saturation is built in.
    function automatic logic [DW-1:0] madd(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef ACC_SAT_EN
        longint s;
        s = longint'($signed(a)) + longint'($signed(b));
        if (s > SMAX) return 32'h7FFF_FFFF;
        if (s < SMIN) return 32'h8000_0000;
        return s[31:0];
`else
        return a + b;
`endif
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic acc_write(input int sel, input logic [L-1:0] en, input logic mode,
                             input logic [L*DW-1:0] d);
        acc_sel_w = 5'(sel);
        word_en   = en;
        acc_mode  = mode;
        wdata     = d;
        acc_wen   = 1'b1;
        tick();
        acc_wen = 1'b0;
        for (int i = 0; i < L; i++) begin
            if (en[i]) begin
                int idx;
                idx = (sel + i) % D;
                model_acc[idx] = mode ? madd(model_acc[idx], d[i*DW +: DW]) : d[i*DW +: DW];
            end
        end
    endtask

    task automatic check_read(input string name, input int sel);
        acc_sel_r = 5'(sel);
        #1;
        for (int i = 0; i < L; i++) begin
            check(name, rdata_acc[i*DW +: DW], model_acc[(sel + i) % D]);
        end
    endtask

    task automatic check_all_acc(input string name);
        for (int b = 0; b < D; b += L) check_read(name, b);
    endtask

    task automatic act_write(input int sel, input logic [DW-1:0] d);
        act_sel_w = 2'(sel);
        wdata[DW-1:0] = d;
        act_wen = 1'b1;
        tick();
        act_wen = 1'b0;
        model_act[sel] = d;
    endtask

    task automatic check_act(input string name, input int sel);
        act_sel_r = 2'(sel);
        #1;
        check(name, rdata_act, model_act[sel]);
    endtask

    task automatic push_drain_expect();
        for (int i = 0; i < D; i++) exp_q.push_back({model_acc[i], 5'(i), i == D - 1});
    endtask

    // Drain monitor: every presented word must match the scoreboard head; pop on handshake.
    always @(negedge CLK) begin
        if (!RST && !clr) begin
            if (drain_done) done_cnt++;
            if (drain_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL drain_unexpected: got idx %0d, required no word", drain_idx);
                end else begin
                    check("drain_data", drain_data, exp_q[0].data);
                    check("drain_idx", 32'(drain_idx), 32'(exp_q[0].idx));
                    check("drain_last", 32'(drain_last), 32'(exp_q[0].last));
                    if (drain_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [L*DW-1:0] d;
        int base;
        RST = 1'b1; clr = 1'b0; wdata = '0; word_en = '0; acc_wen = 1'b0; acc_mode = 1'b0;
        acc_sel_w = '0; acc_sel_r = '0; act_wen = 1'b0; act_sel_w = '0; act_sel_r = '0;
        drain_start = 1'b0; drain_ready = 1'b0;
        for (int i = 0; i < D; i++) model_acc[i] = '0;
        for (int i = 0; i < AD; i++) model_act[i] = '0;
        tick(); tick();
        RST = 1'b0;

        // Reset state
        check("rst_busy", 32'(drain_busy), 0);
        check("rst_valid", 32'(drain_valid), 0);
        check("rst_done", 32'(drain_done), 0);
        check("rst_idx", 32'(drain_idx), 0);
        check_read("rst_acc", 20);
        check_act("rst_act", 3);

        // Wrap-around 4-lane overwrite at 30
        acc_write(30, 4'hf, 1'b0, {32'd4, 32'd3, 32'd2, 32'd1});
        check_read("wrap_read", 30);
        acc_sel_r = 5'd0; #1;
        check("wrap_acc0", rdata_acc[DW-1:0], 32'd3);

        // Accumulate, with same-cycle read not forwarded
        acc_write(5, 4'b0001, 1'b0, {96'd0, 32'd10});
        acc_sel_w = 5'd5; word_en = 4'b0001; acc_mode = 1'b1; wdata = {96'd0, 32'd7};
        acc_wen = 1'b1; acc_sel_r = 5'd5; #1;
        check("no_forward", rdata_acc[DW-1:0], 32'd10);
        tick();
        acc_wen = 1'b0;
        model_acc[5] = madd(model_acc[5], 32'd7);
        check("accum_17", rdata_acc[DW-1:0], 32'd17);

        // Overflow boundary
        acc_write(0, 4'b0001, 1'b0, {96'd0, 32'h7FFF_FFFF});
        acc_write(0, 4'b0001, 1'b1, {96'd0, 32'd1});
        acc_sel_r = 5'd0; #1;
`ifdef ACC_SAT_EN
        check("overflow", rdata_acc[DW-1:0], 32'h7FFF_FFFF);
`else
        check("overflow", rdata_acc[DW-1:0], 32'h8000_0000);
`endif

        // Sparse lane enable and activation write
        acc_write(8, 4'b0101, 1'b0, {$urandom, $urandom, $urandom, $urandom});
        check_read("sparse_en", 8);
        act_write(2, $urandom);
        check_act("act_sel2", 2);

        // Randomized writes and reads
        for (int n = 0; n < 60; n++) begin
            for (int i = 0; i < L; i++) begin
                d[i*DW +: DW] = ($urandom_range(0, 3) == 0) ? (32'h7FFF_FFF0 + 32'($urandom_range(0, 31)))
                                                           : 32'($urandom);
            end
            acc_write(int'($urandom_range(0, D - 1)), 4'($urandom), 1'($urandom), d);
            check_read("rand_read", int'($urandom_range(0, D - 1)));
            if (n % 4 == 0) begin
                act_write(int'($urandom_range(0, AD - 1)), $urandom);
                check_act("rand_act", int'($urandom_range(0, AD - 1)));
            end
        end

        // Drain with ready toggling 1,0,...; writes during drain must be dropped
        for (int b = 0; b < D; b += L) begin
            for (int i = 0; i < L; i++) d[i*DW +: DW] = 32'(b + i);
            acc_write(b, 4'hf, 1'b0, d);
        end
        push_drain_expect();
        base = done_cnt;
        drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
        check("drain_busy_start", 32'(drain_busy), 1);
        for (int c = 0; c < 300 && done_cnt == base; c++) begin
            drain_ready = (c % 2 == 0);
            acc_sel_w = 5'($urandom); word_en = 4'hf; acc_mode = 1'($urandom);
            wdata = {$urandom, $urandom, $urandom, $urandom};
            acc_wen = 1'b1;
            tick();
        end
        acc_wen = 1'b0; drain_ready = 1'b0;
        check("drain_done_count", 32'(done_cnt - base), 1);
        tick(); tick();
        check("drain_done_once", 32'(done_cnt - base), 1);
        check("drain_q_empty", 32'(exp_q.size()), 0);
        check("drain_busy_end", 32'(drain_busy), 0);
        check("drain_idx_end", 32'(drain_idx), 0);
        check_all_acc("drain_snapshot");

        // Drain aborted by clr at idx 7: no done pulse, everything cleared
        for (int n = 0; n < 8; n++) begin
            acc_write(n * 4, 4'hf, 1'b0, {$urandom, $urandom, $urandom, $urandom});
        end
        act_write(1, $urandom);
        push_drain_expect();
        base = done_cnt;
        drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
        for (int c = 0; c < 300 && drain_idx != 5'd7; c++) begin
            drain_ready = 1'($urandom);
            tick();
        end
        check("clr_reach_idx7", 32'(drain_idx), 7);
        clr = 1'b1;
        tick();
        clr = 1'b0; drain_ready = 1'b0;
        exp_q.delete();
        for (int i = 0; i < D; i++) model_acc[i] = '0;
        for (int i = 0; i < AD; i++) model_act[i] = '0;
        check("clr_busy", 32'(drain_busy), 0);
        check("clr_valid", 32'(drain_valid), 0);
        check("clr_idx", 32'(drain_idx), 0);
        check_all_acc("clr_acc");
        for (int i = 0; i < AD; i++) check_act("clr_act", i);
        tick(); tick(); tick();
        check("clr_no_done", 32'(done_cnt - base), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
